// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin-gate sensor conditioning, width classification and pulse generation
//
// Purpose: synchronises and debounces the coin-gate optical sensor, measures the
// blocked-beam width of each coin and emits one registered pulse per coin.
// Ports:
//   sys_clk    in   system clock, rising edge
//   sysRstN    in   asynchronous active-low reset
//   piSense    in   raw sensor, async, 1 = beam blocked
//   piInhibit  in   1 = valid coins are rejected
//   poHalf     out  one-cycle pulse, 0.5 coin accepted
//   poOne      out  one-cycle pulse, 1.0 coin accepted
//   poReject   out  one-cycle pulse, fire reject flap
//   poJam      out  level, coin jammed in gate
//   poBusy     out  level, state != IDLE
module coin_acceptor #(
  parameter int DEB_CYC  = 4,
  parameter int HALF_MIN = 20,
  parameter int HALF_MAX = 39,
  parameter int ONE_MIN  = 40,
  parameter int ONE_MAX  = 79,
  parameter int JAM_CYC  = 200,
  parameter int CNT_W    = 8
) (
  input  logic sys_clk,
  input  logic sysRstN,
  input  logic piSense,
  input  logic piInhibit,
  output logic poHalf,
  output logic poOne,
  output logic poReject,
  output logic poJam,
  output logic poBusy
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2,
    JAM     = 2'd3
  } state_e;

  logic             sync1_q, sync2_q;
  logic             sense_f_q, sense_f_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  state_e           state_q, state_d;
  logic             half_q, half_d;
  logic             one_q, one_d;
  logic             rej_q, rej_d;
  logic             jam_q, jam_d;
  logic             busy_q, busy_d;
  logic             is_half, is_one;

  // Debounce: the filtered level follows sense_s only after DEB_CYC consecutive
  // disagreeing cycles; a single agreeing cycle restarts the count.
  always_comb begin
    deb_cnt_d = '0;
    sense_f_d = sense_f_q;
    if (sync2_q != sense_f_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
        sense_f_d = ~sense_f_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign is_half = (cnt_q >= CNT_W'(HALF_MIN)) && (cnt_q <= CNT_W'(HALF_MAX));
  assign is_one  = (cnt_q >= CNT_W'(ONE_MIN))  && (cnt_q <= CNT_W'(ONE_MAX));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = 1'b0;
    one_d   = 1'b0;
    rej_d   = 1'b0;
    jam_d   = jam_q;
    case (state_q)
      ARM: begin
        // A coin already in the gate at reset is let through unpaid.
        if (!sense_f_q) state_d = IDLE;
      end
      IDLE: begin
        // IDLE is only entered with sense_f low, so a high level is a rising edge.
        // The count starts at 1 because this cycle is already the first high one.
        if (sense_f_q) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!sense_f_q) begin
          state_d = IDLE;
          if (piInhibit)    rej_d  = 1'b1;
          else if (is_half) half_d = 1'b1;
          else if (is_one)  one_d  = 1'b1;
          else              rej_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(JAM_CYC)) begin
            state_d = JAM;
            jam_d   = 1'b1;
          end
        end
      end
      JAM: begin
        if (!sense_f_q) begin
          jam_d   = 1'b0;
          rej_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = ARM;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sense_f_q <= 1'b1;
      deb_cnt_q <= '0;
      cnt_q     <= '0;
      state_q   <= ARM;
      half_q    <= 1'b0;
      one_q     <= 1'b0;
      rej_q     <= 1'b0;
      jam_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= piSense;
      sync2_q   <= sync1_q;
      sense_f_q <= sense_f_d;
      deb_cnt_q <= deb_cnt_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      half_q    <= half_d;
      one_q     <= one_d;
      rej_q     <= rej_d;
      jam_q     <= jam_d;
      busy_q    <= busy_d;
    end
  end

  assign poHalf   = half_q;
  assign poOne    = one_q;
  assign poReject = rej_q;
  assign poJam    = jam_q;
  assign poBusy   = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor
module tb_coin_acceptor;

  logic sys_clk = 1'b0;
  logic sysRstN;
  logic piSense;
  logic piInhibit;
  logic poHalf, poOne, poReject, poJam, poBusy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int half_cnt = 0, one_cnt = 0, rej_cnt = 0, multi_cnt = 0, jam_rise = 0;
  int last_pulse_cyc = 0;
  logic jam_prev = 1'b0;
  int rise_cyc, fall_cyc;

  coin_acceptor dut (
    .sys_clk  (sys_clk),
    .sysRstN  (sysRstN),
    .piSense  (piSense),
    .piInhibit(piInhibit),
    .poHalf   (poHalf),
    .poOne    (poOne),
    .poReject (poReject),
    .poJam    (poJam),
    .poBusy   (poBusy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles, so a pulse wider than one cycle shows up as an extra count.
  always @(negedge sys_clk) begin
    if (poHalf)   half_cnt <= half_cnt + 1;
    if (poOne)    one_cnt  <= one_cnt + 1;
    if (poReject) rej_cnt  <= rej_cnt + 1;
    if (poHalf || poOne || poReject) last_pulse_cyc <= cyc;
    if ((int'(poHalf) + int'(poOne) + int'(poReject)) > 1) multi_cnt <= multi_cnt + 1;
    if (poJam && !jam_prev) jam_rise <= jam_rise + 1;
    jam_prev <= poJam;
  end

  task automatic drive_coin(input int width, input logic inh, input int settle);
    @(posedge sys_clk); #1;
    piInhibit = inh;
    piSense   = 1'b1;
    rise_cyc  = cyc;
    repeat (width) @(posedge sys_clk);
    #1;
    piSense  = 1'b0;
    fall_cyc = cyc;
    repeat (settle) @(posedge sys_clk);
    #1;
    piInhibit = 1'b0;
  endtask

  task automatic test_reset;
    sysRstN = 1'b0; piSense = 1'b0; piInhibit = 1'b0;
    #1;
    checks++; if (poHalf !== 1'b0)   begin failures++; $display("FAIL reset_half got=%b exp=0", poHalf); end
    checks++; if (poOne !== 1'b0)    begin failures++; $display("FAIL reset_one got=%b exp=0", poOne); end
    checks++; if (poReject !== 1'b0) begin failures++; $display("FAIL reset_reject got=%b exp=0", poReject); end
    checks++; if (poJam !== 1'b0)    begin failures++; $display("FAIL reset_jam got=%b exp=0", poJam); end
    checks++; if (poBusy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", poBusy); end
    repeat (3) @(posedge sys_clk);
    #1 sysRstN = 1'b1;
    @(posedge sys_clk); #1;
    checks++; if (poBusy !== 1'b1) begin failures++; $display("FAIL arm_busy got=%b exp=1", poBusy); end
    repeat (11) @(posedge sys_clk); #1;
    checks++; if (poBusy !== 1'b0) begin failures++; $display("FAIL idle_after_arm got=%b exp=0", poBusy); end
  endtask

  task automatic test_half_latency;
    int h0, o0, r0;
    h0 = half_cnt; o0 = one_cnt; r0 = rej_cnt;
    drive_coin(30, 1'b0, 20);
    checks++; if (half_cnt - h0 !== 1) begin failures++; $display("FAIL half30_count got=%0d exp=1", half_cnt - h0); end
    checks++; if ((one_cnt - o0) + (rej_cnt - r0) !== 0) begin failures++; $display("FAIL half30_other got=%0d exp=0", (one_cnt - o0) + (rej_cnt - r0)); end
    checks++; if (last_pulse_cyc - fall_cyc !== 7) begin failures++; $display("FAIL half30_latency got=%0d exp=7", last_pulse_cyc - fall_cyc); end
  endtask

  task automatic test_widths;
    int w[9]   = '{60, 10, 90, 19, 20, 39, 40, 79, 80};
    int cls[9] = '{2, 0, 0, 0, 1, 1, 2, 2, 0};
    int h0, o0, r0;
    for (int i = 0; i < 9; i++) begin
      h0 = half_cnt; o0 = one_cnt; r0 = rej_cnt;
      drive_coin(w[i], 1'b0, 20);
      checks++; if (half_cnt - h0 !== int'(cls[i] == 1)) begin failures++; $display("FAIL width%0d_half got=%0d exp=%0d", w[i], half_cnt - h0, int'(cls[i] == 1)); end
      checks++; if (one_cnt - o0 !== int'(cls[i] == 2))  begin failures++; $display("FAIL width%0d_one got=%0d exp=%0d", w[i], one_cnt - o0, int'(cls[i] == 2)); end
      checks++; if (rej_cnt - r0 !== int'(cls[i] == 0))  begin failures++; $display("FAIL width%0d_reject got=%0d exp=%0d", w[i], rej_cnt - r0, int'(cls[i] == 0)); end
    end
  endtask

  task automatic test_inhibit;
    int h0, o0, r0;
    h0 = half_cnt; o0 = one_cnt; r0 = rej_cnt;
    drive_coin(45, 1'b1, 20);
    checks++; if (rej_cnt - r0 !== 1) begin failures++; $display("FAIL inhibit_reject got=%0d exp=1", rej_cnt - r0); end
    checks++; if ((one_cnt - o0) + (half_cnt - h0) !== 0) begin failures++; $display("FAIL inhibit_paid got=%0d exp=0", (one_cnt - o0) + (half_cnt - h0)); end
  endtask

  task automatic test_bounce;
    int h0, o0, r0;
    logic [5:0] rise_pat, fall_pat;
    h0 = half_cnt; o0 = one_cnt; r0 = rej_cnt;
    for (int g = 0; g < 3; g++) begin
      @(posedge sys_clk); #1 piSense = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 piSense = 1'b0;
      repeat (5) @(posedge sys_clk);
    end
    repeat (10) @(posedge sys_clk); #1;
    checks++; if ((half_cnt - h0) + (one_cnt - o0) + (rej_cnt - r0) !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", (half_cnt - h0) + (one_cnt - o0) + (rej_cnt - r0)); end
    checks++; if (poBusy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", poBusy); end
    rise_pat = 6'b001100;
    fall_pat = 6'b110011;
    for (int k = 0; k < 4; k++) begin
      @(posedge sys_clk); #1 piSense = rise_pat[5 - k];
    end
    repeat (30) begin
      @(posedge sys_clk); #1 piSense = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge sys_clk); #1 piSense = ~fall_pat[5 - k];
    end
    piSense = 1'b0;
    repeat (20) @(posedge sys_clk); #1;
    checks++; if (half_cnt - h0 !== 1) begin failures++; $display("FAIL bounce_half got=%0d exp=1", half_cnt - h0); end
    checks++; if ((one_cnt - o0) + (rej_cnt - r0) !== 0) begin failures++; $display("FAIL bounce_other got=%0d exp=0", (one_cnt - o0) + (rej_cnt - r0)); end
  endtask

  task automatic test_jam;
    int h0, o0, r0, j0, r, f;
    h0 = half_cnt; o0 = one_cnt; r0 = rej_cnt; j0 = jam_rise;
    @(posedge sys_clk); #1 piSense = 1'b1; r = cyc;
    repeat (205) @(posedge sys_clk); #1;
    checks++; if (poJam !== 1'b0) begin failures++; $display("FAIL jam_early got=%b exp=0", poJam); end
    @(posedge sys_clk); #1;
    checks++; if (poJam !== 1'b1) begin failures++; $display("FAIL jam_at_200 got=%b exp=1", poJam); end
    repeat (44) @(posedge sys_clk);
    #1 piSense = 1'b0; f = cyc;
    checks++; if (f - r !== 250) begin failures++; $display("FAIL jam_raw_width got=%0d exp=250", f - r); end
    repeat (6) @(posedge sys_clk); #1;
    checks++; if (poJam !== 1'b1) begin failures++; $display("FAIL jam_hold got=%b exp=1", poJam); end
    @(posedge sys_clk); #1;
    checks++; if (poJam !== 1'b0)    begin failures++; $display("FAIL jam_release got=%b exp=0", poJam); end
    checks++; if (poReject !== 1'b1) begin failures++; $display("FAIL jam_reject_pulse got=%b exp=1", poReject); end
    repeat (10) @(posedge sys_clk); #1;
    checks++; if (rej_cnt - r0 !== 1) begin failures++; $display("FAIL jam_reject_count got=%0d exp=1", rej_cnt - r0); end
    checks++; if ((half_cnt - h0) + (one_cnt - o0) !== 0) begin failures++; $display("FAIL jam_paid got=%0d exp=0", (half_cnt - h0) + (one_cnt - o0)); end
    checks++; if (jam_rise - j0 !== 1) begin failures++; $display("FAIL jam_rise_count got=%0d exp=1", jam_rise - j0); end
  endtask

  task automatic test_reset_mid_coin;
    int h0, o0, r0;
    h0 = half_cnt; o0 = one_cnt; r0 = rej_cnt;
    @(posedge sys_clk); #1 piSense = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1 sysRstN = 1'b0;
    #1;
    checks++; if ({poHalf, poOne, poReject, poJam, poBusy} !== 5'b0) begin failures++; $display("FAIL midreset_outputs got=%b exp=00000", {poHalf, poOne, poReject, poJam, poBusy}); end
    repeat (2) @(posedge sys_clk);
    #1 sysRstN = 1'b1;
    repeat (36) @(posedge sys_clk); #1;
    checks++; if (poBusy !== 1'b1) begin failures++; $display("FAIL midreset_arm_busy got=%b exp=1", poBusy); end
    piSense = 1'b0;
    repeat (20) @(posedge sys_clk); #1;
    checks++; if (poBusy !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%b exp=0", poBusy); end
    checks++; if ((half_cnt - h0) + (one_cnt - o0) + (rej_cnt - r0) !== 0) begin failures++; $display("FAIL midreset_pulses got=%0d exp=0", (half_cnt - h0) + (one_cnt - o0) + (rej_cnt - r0)); end
  endtask

  task automatic test_back_to_back;
    int h0, o0;
    h0 = half_cnt; o0 = one_cnt;
    drive_coin(25, 1'b0, 7);
    drive_coin(50, 1'b0, 20);
    checks++; if (half_cnt - h0 !== 1) begin failures++; $display("FAIL b2b_half got=%0d exp=1", half_cnt - h0); end
    checks++; if (one_cnt - o0 !== 1)  begin failures++; $display("FAIL b2b_one got=%0d exp=1", one_cnt - o0); end
    checks++; if (multi_cnt !== 0) begin failures++; $display("FAIL exclusive_pulses got=%0d exp=0", multi_cnt); end
  endtask

  initial begin
    test_reset;
    test_half_latency;
    test_widths;
    test_inhibit;
    test_bounce;
    test_jam;
    test_reset_mid_coin;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
